ethernet_preamble_sync: RTL and testbench

- Parametrised successor to the fixed single-SFD preamble detector.
- Qualifies the full preamble: a run of 0x55 bytes of bounded length, then SFD 0xD5.
- Passes post-SFD payload bytes downstream, reports frame boundaries and length, and re-arms for every frame.
- Sits between the PHY byte assembler (RMII/MII nibble-to-byte) and the MAC frame parser/CRC checker.

---
 rtl/ethernet_preamble_sync.sv | 149 ++++++++++++++
 tb/tb_ethernet_preamble_sync.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_preamble_sync.sv
// Ethernet preamble/SFD qualifier: validates the 0x55 run and the 0xD5 delimiter,
// then forwards payload bytes and reports frame boundaries, length and preamble errors.
module ethernet_preamble_sync #(
    parameter int unsigned MIN_PREAMBLE = 2,
    parameter int unsigned MAX_PREAMBLE = 15,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned LEN_W        = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_active,
    input  logic             byte_ready,
    input  logic [7:0]       rx_byte,
    output logic             sfd_detected,
    output logic             in_frame,
    output logic             payload_valid,
    output logic [7:0]       payload_byte,
    output logic             frame_end,
    output logic [LEN_W-1:0] frame_len,
    output logic             preamble_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [7:0]       PRE_BYTE = 8'h55;
    localparam logic [7:0]       SFD_BYTE = 8'hD5;
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PREAMBLE);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PREAMBLE);
    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d, pre_cnt_inc;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic             sfd_q, sfd_d;
    logic             in_frame_q, in_frame_d;
    logic             pv_q, pv_d;
    logic [7:0]       pbyte_q, pbyte_d;
    logic             fend_q, fend_d;
    logic [LEN_W-1:0] flen_q, flen_d;
    logic             perr_q, perr_d;

    assign pre_cnt_inc = pre_cnt_q + CNT_W'(1);

    // Next-state and registered-output computation; carrier loss outranks byte_ready.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        len_cnt_d = len_cnt_q;
        sfd_d     = 1'b0;
        pv_d      = 1'b0;
        pbyte_d   = pbyte_q;
        fend_d    = 1'b0;
        flen_d    = flen_q;
        perr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_active && byte_ready) begin
                    if (rx_byte == PRE_BYTE) begin
                        state_d   = S_PRE;
                        pre_cnt_d = CNT_W'(1);
                    end else begin
                        state_d = S_DRAIN;
                        perr_d  = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (!rx_active) begin
                    state_d   = S_IDLE;
                    perr_d    = 1'b1;
                    pre_cnt_d = '0;
                end else if (byte_ready) begin
                    if (rx_byte == PRE_BYTE) begin
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == MAX_CNT) begin
                            state_d = S_DRAIN;
                            perr_d  = 1'b1;
                        end
                    end else if (rx_byte == SFD_BYTE && pre_cnt_q >= MIN_CNT) begin
                        state_d   = S_FRAME;
                        sfd_d     = 1'b1;
                        len_cnt_d = '0;
                    end else begin
                        state_d = S_DRAIN;
                        perr_d  = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                if (!rx_active) begin
                    state_d = S_IDLE;
                    fend_d  = 1'b1;
                    flen_d  = len_cnt_q;
                end else if (byte_ready) begin
                    pv_d    = 1'b1;
                    pbyte_d = rx_byte;
                    if (len_cnt_q != LEN_MAX) begin
                        len_cnt_d = len_cnt_q + LEN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!rx_active) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_frame_d = (state_d == S_FRAME);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            len_cnt_q  <= '0;
            sfd_q      <= 1'b0;
            in_frame_q <= 1'b0;
            pv_q       <= 1'b0;
            pbyte_q    <= '0;
            fend_q     <= 1'b0;
            flen_q     <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            len_cnt_q  <= len_cnt_d;
            sfd_q      <= sfd_d;
            in_frame_q <= in_frame_d;
            pv_q       <= pv_d;
            pbyte_q    <= pbyte_d;
            fend_q     <= fend_d;
            flen_q     <= flen_d;
            perr_q     <= perr_d;
        end
    end

    assign sfd_detected   = sfd_q;
    assign in_frame       = in_frame_q;
    assign payload_valid  = pv_q;
    assign payload_byte   = pbyte_q;
    assign frame_end      = fend_q;
    assign frame_len      = flen_q;
    assign preamble_error = perr_q;

endmodule

// File: tb/tb_ethernet_preamble_sync.sv
// Randomized bench for ethernet_preamble_sync: each carrier burst is parsed as a byte list
// by a reference model and compared cycle-by-cycle against two instances (LEN_W=11 and 4).
module tb_ethernet_preamble_sync;

    localparam int MIN_P = 2;
    localparam int MAX_P = 15;
    localparam int LW_A  = 11;
    localparam int LW_B  = 4;

    logic clk = 1'b0;
    logic reset, rx_active, byte_ready;
    logic [7:0] rx_byte;

    logic a_sfd, a_inf, a_pv, a_fend, a_perr;
    logic [7:0] a_pbyte;
    logic [LW_A-1:0] a_flen;
    logic b_sfd, b_inf, b_pv, b_fend, b_perr;
    logic [7:0] b_pbyte;
    logic [LW_B-1:0] b_flen;

    always #5 clk = ~clk;

    ethernet_preamble_sync #(.MIN_PREAMBLE(MIN_P), .MAX_PREAMBLE(MAX_P), .CNT_W(4), .LEN_W(LW_A)) dut_a (
        .clk(clk), .reset(reset), .rx_active(rx_active), .byte_ready(byte_ready), .rx_byte(rx_byte),
        .sfd_detected(a_sfd), .in_frame(a_inf), .payload_valid(a_pv), .payload_byte(a_pbyte),
        .frame_end(a_fend), .frame_len(a_flen), .preamble_error(a_perr));

    ethernet_preamble_sync #(.MIN_PREAMBLE(MIN_P), .MAX_PREAMBLE(MAX_P), .CNT_W(4), .LEN_W(LW_B)) dut_b (
        .clk(clk), .reset(reset), .rx_active(rx_active), .byte_ready(byte_ready), .rx_byte(rx_byte),
        .sfd_detected(b_sfd), .in_frame(b_inf), .payload_valid(b_pv), .payload_byte(b_pbyte),
        .frame_end(b_fend), .frame_len(b_flen), .preamble_error(b_perr));

    typedef struct {
        bit sfd, inf, pv, fend, perr;
        int pbyte, flen;
    } obs_t;

    int errs = 0;
    int checks = 0;
    int exp_len_a = 0;
    int exp_len_b = 0;
    obs_t oa[$], ob[$];
    bit s_rdy[$];
    logic [7:0] s_dat[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic obs_t samp_a();
        obs_t o;
        o.sfd = a_sfd; o.inf = a_inf; o.pv = a_pv; o.fend = a_fend; o.perr = a_perr;
        o.pbyte = int'(a_pbyte); o.flen = int'(a_flen);
        return o;
    endfunction

    function automatic obs_t samp_b();
        obs_t o;
        o.sfd = b_sfd; o.inf = b_inf; o.pv = b_pv; o.fend = b_fend; o.perr = b_perr;
        o.pbyte = int'(b_pbyte); o.flen = int'(b_flen);
        return o;
    endfunction

    // One clock: drive inputs, let the edge pass, record both instances' responses.
    task automatic tick(input logic act, input logic rdy, input logic [7:0] d);
        rx_active = act; byte_ready = rdy; rx_byte = d;
        @(posedge clk);
        #1;
        oa.push_back(samp_a());
        ob.push_back(samp_b());
    endtask

    task automatic add(input logic [7:0] d, input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_rdy.push_back(1'b0);
            s_dat.push_back(8'($urandom));
        end
        s_rdy.push_back(1'b1);
        s_dat.push_back(d);
    endtask

    task automatic check_all_zero(input string tag);
        obs_t x, y;
        x = samp_a(); y = samp_b();
        check_eq({tag, ".a.sum"}, int'(x.sfd) + int'(x.inf) + int'(x.pv) + int'(x.fend) + int'(x.perr), 0);
        check_eq({tag, ".a.pbyte"}, x.pbyte, 0);
        check_eq({tag, ".a.flen"}, x.flen, 0);
        check_eq({tag, ".b.sum"}, int'(y.sfd) + int'(y.inf) + int'(y.pv) + int'(y.fend) + int'(y.perr), 0);
        check_eq({tag, ".b.pbyte"}, y.pbyte, 0);
        check_eq({tag, ".b.flen"}, y.flen, 0);
    endtask

    // Play the queued carrier burst, then 'gap' idle cycles, and check against the byte-list model.
    task automatic run_burst(input string name, input int gap, input bit gap_rdy_first);
        int L, n, cnt, sfd_idx, tot, la, lb, pla, plb;
        bit framed, decided;
        bit e_sfd[], e_pv[], e_fend[], e_perr[], e_inf[];
        int e_pb[];
        L = s_rdy.size();
        tot = L + gap;
        oa.delete(); ob.delete();
        for (int i = 0; i < L; i++) tick(1'b1, s_rdy[i], s_dat[i]);
        for (int g = 0; g < gap; g++)
            tick(1'b0, (g == 0) ? gap_rdy_first : 1'($urandom_range(0, 1)), 8'($urandom));

        e_sfd = new[tot]; e_pv = new[tot]; e_fend = new[tot]; e_perr = new[tot];
        e_inf = new[tot]; e_pb = new[tot];
        n = 0; cnt = 0; sfd_idx = -1; framed = 0; decided = 0;
        for (int i = 0; i < L; i++) begin
            if (!s_rdy[i]) continue;
            if (framed) begin
                e_pv[i] = 1; e_pb[i] = int'(s_dat[i]); n++;
            end else if (!decided) begin
                if (s_dat[i] == 8'h55) begin
                    cnt++;
                    if (cnt == MAX_P) begin e_perr[i] = 1; decided = 1; end
                end else if (s_dat[i] == 8'hD5 && cnt >= MIN_P && cnt >= 1) begin
                    e_sfd[i] = 1; framed = 1; sfd_idx = i;
                end else begin
                    e_perr[i] = 1; decided = 1;
                end
            end
        end
        if (framed) begin
            e_fend[L] = 1;
            for (int j = sfd_idx; j < L; j++) e_inf[j] = 1;
        end else if (!decided && cnt > 0) begin
            e_perr[L] = 1;
        end
        pla = exp_len_a; plb = exp_len_b;
        if (framed) begin
            exp_len_a = (n > (1 << LW_A) - 1) ? (1 << LW_A) - 1 : n;
            exp_len_b = (n > (1 << LW_B) - 1) ? (1 << LW_B) - 1 : n;
        end

        for (int j = 0; j < tot; j++) begin
            la = (j >= L) ? exp_len_a : pla;
            lb = (j >= L) ? exp_len_b : plb;
            check_eq($sformatf("%s.a.sfd[%0d]", name, j), int'(oa[j].sfd), int'(e_sfd[j]));
            check_eq($sformatf("%s.a.inf[%0d]", name, j), int'(oa[j].inf), int'(e_inf[j]));
            check_eq($sformatf("%s.a.pv[%0d]", name, j), int'(oa[j].pv), int'(e_pv[j]));
            check_eq($sformatf("%s.a.fend[%0d]", name, j), int'(oa[j].fend), int'(e_fend[j]));
            check_eq($sformatf("%s.a.perr[%0d]", name, j), int'(oa[j].perr), int'(e_perr[j]));
            check_eq($sformatf("%s.a.flen[%0d]", name, j), oa[j].flen, la);
            check_eq($sformatf("%s.b.sfd[%0d]", name, j), int'(ob[j].sfd), int'(e_sfd[j]));
            check_eq($sformatf("%s.b.pv[%0d]", name, j), int'(ob[j].pv), int'(e_pv[j]));
            check_eq($sformatf("%s.b.fend[%0d]", name, j), int'(ob[j].fend), int'(e_fend[j]));
            check_eq($sformatf("%s.b.perr[%0d]", name, j), int'(ob[j].perr), int'(e_perr[j]));
            check_eq($sformatf("%s.b.flen[%0d]", name, j), ob[j].flen, lb);
            if (e_pv[j]) begin
                check_eq($sformatf("%s.a.pbyte[%0d]", name, j), oa[j].pbyte, e_pb[j]);
                check_eq($sformatf("%s.b.pbyte[%0d]", name, j), ob[j].pbyte, e_pb[j]);
            end
        end
        s_rdy.delete(); s_dat.delete();
    endtask

    task automatic nominal(input string name, input int gap);
        for (int i = 0; i < 7; i++) add(8'h55, 0);
        add(8'hD5, 0);
        for (int i = 1; i <= 64; i++) add(8'(i), 0);
        run_burst(name, gap, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        int np, kind, plen;
        reset = 1'b1; rx_active = 1'b0; byte_ready = 1'b0; rx_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        nominal("nominal", 1);

        add(8'h55, 0); add(8'hD5, 0);
        for (int i = 0; i < 5; i++) add(8'($urandom), 1);
        run_burst("short1", 2, 1'b0);
        add(8'h55, 0); add(8'h55, 0); add(8'hD5, 0);
        for (int i = 0; i < 3; i++) add(8'($urandom), 1);
        run_burst("short2", 1, 1'b0);

        for (int i = 0; i < 17; i++) add(8'h55, 0);
        add(8'hD5, 0);
        run_burst("long15", 1, 1'b0);
        add(8'h55, 0); add(8'h55, 0); add(8'h57, 0); add(8'hD5, 0); add(8'h11, 0);
        run_burst("corrupt", 1, 1'b0);

        add(8'h55, 0); add(8'h55, 0); add(8'h55, 0);
        run_burst("trunc", 2, 1'b1);
        add(8'h55, 0); add(8'h55, 0); add(8'hD5, 0);
        add(8'hA1, 0); add(8'h55, 0); add(8'hD5, 0);
        run_burst("prio", 1, 1'b1);

        nominal("b2b1", 1);
        add(8'h55, 0); add(8'h55, 0); add(8'h55, 0); add(8'hD5, 0);
        for (int i = 0; i < 5; i++) add(8'(8'hC0 + i), 0);
        run_burst("b2b2", 1, 1'b0);

        add(8'h55, 0); add(8'h55, 0); add(8'hD5, 0);
        for (int i = 0; i < 20; i++) add(8'($urandom), 0);
        run_burst("sat", 1, 1'b0);

        add(8'hD5, 0); add(8'h55, 0); add(8'hD5, 0);
        run_burst("idle_sfd", 1, 1'b0);

        // Reset in the middle of a frame: no frame_end, then a clean frame.
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 8'h55);
        tick(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 8'(i + 1));
        check_eq("pre_reset.a.inf", int'(a_inf), 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_len_a = 0; exp_len_b = 0;
        run_burst("post_reset", 3, 1'b1);
        nominal("after_reset", 1);

        for (int r = 0; r < 40; r++) begin
            np = $urandom_range(0, 17);
            for (int i = 0; i < np; i++) add(8'h55, 1);
            kind = $urandom_range(0, 3);
            if (kind <= 1) add(8'hD5, 1);
            else if (kind == 2) begin
                do d = 8'($urandom); while (d == 8'h55);
                add(d, 1);
            end
            plen = (kind == 3) ? 0 : $urandom_range(0, 24);
            for (int i = 0; i < plen; i++) begin
                case ($urandom_range(0, 5))
                    0: d = 8'h55;
                    1: d = 8'hD5;
                    default: d = 8'($urandom);
                endcase
                add(d, 1);
            end
            run_burst($sformatf("rand%0d", r), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
